// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/gnt/rvalid
// and hands instructions to decode through an output register plus one prefetch slot.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   input  logic        is_jump,
   input  logic        is_branch,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] addr26
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        pf_valid_q, pf_valid_d;
   logic [31:0] pf_inst_q, pf_inst_d;
   logic [31:0] pf_pc_q, pf_pc_d;
   logic        hold_q, hold_d;
   logic [31:0] hold_addr_q, hold_addr_d;

   logic        transfer;
   logic        redirect;
   logic        fill;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] target;
   logic [31:0] fill_pc;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      pf_valid_d  = pf_valid_q;
      pf_inst_d   = pf_inst_q;
      pf_pc_d     = pf_pc_q;
      hold_d      = hold_q;
      hold_addr_d = hold_addr_q;

      transfer   = out_valid_q && inst_ready;
      redirect   = transfer && (is_jump || (is_branch && branch_taken));
      pc_plus4   = out_pc_q + 32'd4;
      br_target  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      jmp_target = {pc_plus4[31:28], addr26, 2'b00};
      target     = is_jump ? jmp_target : br_target;
      fill       = (state_q == S_WAIT) && imem_rvalid && !redirect;
      // fetch_pc already advanced at grant, so the returning word belongs one slot back
      fill_pc    = fetch_pc_q - 32'd4;

      if (redirect) begin
         out_valid_d = 1'b0;
         pf_valid_d  = 1'b0;
         fetch_pc_d  = target;
      end else if (transfer) begin
         if (pf_valid_q) begin
            out_inst_d = pf_inst_q;
            out_pc_d   = pf_pc_q;
            pf_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end

      if (fill) begin
         if (!out_valid_d) begin
            out_valid_d = 1'b1;
            out_inst_d  = imem_rdata;
            out_pc_d    = fill_pc;
         end else begin
            pf_valid_d = 1'b1;
            pf_inst_d  = imem_rdata;
            pf_pc_d    = fill_pc;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (!out_valid_q || !pf_valid_q || transfer)
               state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_gnt) begin
               hold_d = 1'b0;
               if (redirect || hold_q) begin
                  state_d = S_DROP;
               end else begin
                  state_d    = S_WAIT;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end else if (redirect && !hold_q) begin
               // The bus needs the old address until granted; the target waits in fetch_pc.
               hold_d      = 1'b1;
               hold_addr_d = fetch_pc_q;
            end
         end
         S_WAIT: begin
            if (imem_rvalid)
               state_d = (redirect || (out_valid_d && pf_valid_d)) ? S_IDLE : S_REQ;
            else if (redirect)
               state_d = S_DROP;
         end
         S_DROP: begin
            if (imem_rvalid)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RESET_PC;
         out_valid_q <= 1'b0;
         out_inst_q  <= 32'd0;
         out_pc_q    <= 32'd0;
         pf_valid_q  <= 1'b0;
         pf_inst_q   <= 32'd0;
         pf_pc_q     <= 32'd0;
         hold_q      <= 1'b0;
         hold_addr_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
         pf_valid_q  <= pf_valid_d;
         pf_inst_q   <= pf_inst_d;
         pf_pc_q     <= pf_pc_d;
         hold_q      <= hold_d;
         hold_addr_q <= hold_addr_d;
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = hold_q ? hold_addr_q : fetch_pc_q;
   assign inst_valid  = out_valid_q;
   assign instruction = out_inst_q;
   assign inst_pc     = out_pc_q;

endmodule
